div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multicycle iterative divider that serves the datapath's DIV instruction. The Control FSM
//  starts it through divControl and watches div0 to enter ZeroDiv_State. On completion the
//  unit presents quotient/remainder for loading into LO/HI (lodivControl/hidivControl).
//  Restoring radix-2 algorithm, one quotient bit per clk.
// PARAMETERS
//  WIDTH   32   operand, quotient and remainder width in bits
// PORTS
//  clk         in   1      system clock; all state changes on its rising edge
//  reset       in   1      synchronous, active-high reset
//  divControl  in   2      2'b01 = start, 2'b10 = abort, 2'b00/2'b11 = no-op
//  dividend    in   WIDTH  A operand (rs); sampled on the start cycle only
//  divisor     in   WIDTH  B operand (rt); sampled on the start cycle only
//  lo          out  WIDTH  quotient result
//  hi          out  WIDTH  remainder result
//  busy        out  1      division in progress
//  done        out  1      one-cycle pulse: lo/hi valid
//  div0        out  1      one-cycle pulse: divisor was zero
// BEHAVIOUR
//  Reset: state=IDLE; lo, hi, busy, done and div0 all 0; internal registers cleared.
//   Reset in any state, including mid-RUN, aborts the operation and takes priority over divControl.
//  FSM states: IDLE -> LOAD -> RUN -> FIX -> IDLE. A zero divisor goes IDLE -> ZERO -> IDLE.
//  IDLE: on divControl==01 capture both operands. Divisor==0 -> ZERO, otherwise -> LOAD.
//   Other divControl codes are ignored in IDLE.
//  ZERO: div0=1 for exactly this cycle; done stays 0; lo/hi keep their previous values; -> IDLE.
//  LOAD: busy=1; record the operand signs; take magnitudes; clear remainder; counter=WIDTH-1.
//  RUN: busy=1; each cycle rem={rem[WIDTH-2:0],q[WIDTH-1]}, q<<=1, then trial-subtract |divisor|.
//   If no borrow, commit the subtraction and set q[0]=1.
//   Exactly WIDTH cycles, counter decrements; counter==0 -> FIX.
//  FIX: apply sign correction; register lo/hi; done=1 for this one cycle; busy=0; -> IDLE.
//  Timing, with start sampled in cycle 0: busy high cycles 1..WIDTH+1; done high in cycle WIDTH+2.
//   For a zero divisor, div0 is high in cycle 1.
//  A start while busy is ignored. The operands must be held only during cycle 0.
//  divControl==10 in LOAD/RUN: -> IDLE next cycle; busy=0; no done; lo/hi unchanged.
//  lo/hi hold their values until the next successful done. done and div0 are never high together.
//  Back-to-back: a start accepted in the cycle after done begins a new division.
// CONFIGURATION
//  DIV_SIGNED_EN defined: two's-complement (MIPS DIV) semantics.
//   Quotient truncates toward zero; remainder takes the sign of the dividend.
//   0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no div0 and no other flag.
//  DIV_SIGNED_EN undefined: operands are unsigned; the LOAD magnitude step and FIX correction
//   are bypassed. Latency is identical in both builds.
// TESTING
//  1 start, 100/7 -> cycle WIDTH+2: done=1, lo=14, hi=2; busy low afterwards.
//  2 start, 5/0 -> cycle 1: div0=1, done never asserts, lo/hi unchanged, next start accepted.
//  3 signed build, 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//    Unsigned build, same operands -> lo=0x7FFFFFFC, hi=1.
//  4 signed build, 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
//  5 start 100/7, re-start 9/3 at cycle 5 -> second start ignored; result lo=14, hi=2.
//  6 reset at cycle 10 of a RUN -> next cycle busy=0, lo=hi=0, no done. Abort (10) in RUN -> busy=0, lo/hi unchanged.

Source files
------------

// File: rtl/div_unit.sv
// ============================================================================
//  Module      : div_unit
//  Description : Multicycle restoring radix-2 divider, one quotient bit per
//                clock. Serves the DIV instruction; the result is presented
//                on lo (quotient) and hi (remainder).
//  Build option: DIV_SIGNED_EN -- when defined, two's-complement semantics:
//                the quotient truncates toward zero and the remainder takes
//                the dividend's sign. When undefined, the operands are
//                unsigned. Latency is the same in both builds.
//  Ports       : clk        - clock, rising edge
//                reset      - synchronous active-high reset
//                divControl - 01 start, 10 abort, 00/11 no-op
//                dividend   - A operand, sampled on the start cycle only
//                divisor    - B operand, sampled on the start cycle only
//                lo / hi    - quotient / remainder, held until the next done
//                busy       - division in progress (LOAD and RUN)
//                done       - one-cycle pulse, lo/hi valid
//                div0       - one-cycle pulse, divisor was zero
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       divControl,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_ZERO = 3'd1;
    localparam logic [2:0] C_LOAD = 3'd2;
    localparam logic [2:0] C_RUN  = 3'd3;
    localparam logic [2:0] C_FIX  = 3'd4;

    localparam logic [1:0] C_START = 2'b01;
    localparam logic [1:0] C_ABORT = 2'b10;

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH-1:0] w_rem_step;
    logic [WIDTH-1:0] w_lo_fix;
    logic [WIDTH-1:0] w_hi_fix;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_neg_a;
    logic             w_neg_b;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (divControl == C_START) begin
                    w_next = (divisor == '0) ? C_ZERO : C_LOAD;
                end
            end
            C_ZERO:  w_next = C_IDLE;
            C_LOAD:  w_next = (divControl == C_ABORT) ? C_IDLE : C_RUN;
            C_RUN: begin
                if (divControl == C_ABORT) begin
                    w_next = C_IDLE;
                end else if (r_cnt == '0) begin
                    w_next = C_FIX;
                end
            end
            C_FIX:   w_next = C_IDLE;
            default: w_next = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        div0 = 1'b0;
        case (r_state)
            C_LOAD:  busy = 1'b1;
            C_RUN:   busy = 1'b1;
            C_FIX:   done = 1'b1;
            C_ZERO:  div0 = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring step. The shifted remainder keeps one extra bit so that
    // divisors with the MSB set still compare correctly in unsigned mode.
    // ------------------------------------------------------------------
    assign w_shift    = {r_rem, r_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_q_step   = {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_rem_step = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
    assign w_neg_a = r_a[WIDTH-1];
    assign w_neg_b = r_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -r_a : r_a;
    assign w_mag_b = w_neg_b ? -r_b : r_b;
`else
    assign w_neg_a = 1'b0;
    assign w_neg_b = 1'b0;
    assign w_mag_a = r_a;
    assign w_mag_b = r_b;
`endif

    // With the sign flags forced to zero in the unsigned build this
    // correction collapses to a pass-through.
    assign w_lo_fix = r_neg_q ? -w_q_step   : w_q_step;
    assign w_hi_fix = r_neg_r ? -w_rem_step : w_rem_step;

    // ------------------------------------------------------------------
    // Datapath. lo/hi load on the last RUN edge so they are already valid
    // during the FIX cycle in which done is raised.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_q     <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (divControl == C_START) begin
                        r_a <= dividend;
                        r_b <= divisor;
                    end
                end
                C_LOAD: begin
                    r_q     <= w_mag_a;
                    r_dvs   <= w_mag_b;
                    r_rem   <= '0;
                    r_cnt   <= CW'(WIDTH - 1);
                    r_neg_q <= w_neg_a ^ w_neg_b;
                    r_neg_r <= w_neg_a;
                end
                C_RUN: begin
                    r_q   <= w_q_step;
                    r_rem <= w_rem_step;
                    r_cnt <= r_cnt - 1'b1;
                    if ((r_cnt == '0) && (divControl != C_ABORT)) begin
                        r_lo <= w_lo_fix;
                        r_hi <= w_hi_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lo = r_lo;
    assign hi = r_hi;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none

module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   divControl;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         busy;
    logic         done;
    logic         div0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .divControl (divControl),
        .dividend   (dividend),
        .divisor    (divisor),
        .lo         (lo),
        .hi         (hi),
        .busy       (busy),
        .done       (done),
        .div0       (div0)
    );

    // Reference: plain arithmetic on magnitudes, then sign rules.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
        logic [W-1:0] ma, mb, uq, ur;
        if (b == '0) begin
            q = '0;
            r = '0;
        end else begin
`ifdef DIV_SIGNED_EN
            ma = a[W-1] ? -a : a;
            mb = b[W-1] ? -b : b;
            uq = ma / mb;
            ur = ma % mb;
            q  = (a[W-1] ^ b[W-1]) ? -uq : uq;
            r  = a[W-1] ? -ur : ur;
`else
            ma = a;
            mb = b;
            q  = ma / mb;
            r  = ma % mb;
`endif
        end
    endtask

    // Drives a start for one cycle (cycle 0); returns at the cycle-1 sample point.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        divControl = 2'b01;
        dividend   = a;
        divisor    = b;
        @(negedge clk);
        divControl = 2'b00;
        dividend   = $urandom;
        divisor    = $urandom;
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] plo, phi, eq, er;
        int cyc;
        bit bad;
        plo = lo;
        phi = hi;
        model(a, b, eq, er);
        start(a, b);
        if (b == '0) begin
            checks++;
            if (div0 !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s div0_pulse: div0=%b busy=%b done=%b required div0=1 busy=0 done=0", tag, div0, busy, done);
            end
            bad = 0;
            repeat (W + 4) begin
                @(negedge clk);
                if (done !== 1'b0 || div0 !== 1'b0) bad = 1;
            end
            checks++;
            if (bad || lo !== plo || hi !== phi) begin
                errors++;
                $display("FAIL %s div0_hold: lo=%h hi=%h stray=%0d required lo=%h hi=%h stray=0", tag, lo, hi, bad, plo, phi);
            end
        end else begin
            cyc = 1;
            bad = 0;
            while (done !== 1'b1 && cyc < W + 10) begin
                if (busy !== 1'b1 || div0 !== 1'b0) bad = 1;
                @(negedge clk);
                cyc++;
            end
            checks++;
            if (cyc != W + 2 || bad) begin
                errors++;
                $display("FAIL %s latency: done_cycle=%0d busy_glitch=%0d required done_cycle=%0d busy_glitch=0", tag, cyc, bad, W + 2);
            end
            checks++;
            if (lo !== eq || hi !== er || busy !== 1'b0 || div0 !== 1'b0) begin
                errors++;
                $display("FAIL %s result: %h/%h lo=%h hi=%h busy=%b div0=%b required lo=%h hi=%h busy=0 div0=0",
                         tag, a, b, lo, hi, busy, div0, eq, er);
            end
        end
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        divControl = 2'b00;
        dividend   = '0;
        divisor    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (lo !== '0 || hi !== '0 || busy !== 1'b0 || done !== 1'b0 || div0 !== 1'b0) begin
            errors++;
            $display("FAIL reset: lo=%h hi=%h busy=%b done=%b div0=%b required all zero", lo, hi, busy, done, div0);
        end
    endtask

    task automatic test_basic;
        run_div(32'd100, 32'd7, "basic_100_7");
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL basic_const: lo=%0d hi=%0d required lo=14 hi=2", lo, hi);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b busy=%b required done=0 busy=0", done, busy);
        end
    endtask

    task automatic test_div0;
        run_div(32'd5, 32'd0, "div0_5_0");
        run_div(32'd50, 32'd6, "after_div0");
    endtask

    task automatic test_corner;
        logic [W-1:0] el, eh;
        run_div(32'hFFFF_FFF9, 32'd2, "neg7_by_2");
`ifdef DIV_SIGNED_EN
        el = 32'hFFFF_FFFD;
        eh = 32'hFFFF_FFFF;
`else
        el = 32'h7FFF_FFFC;
        eh = 32'h0000_0001;
`endif
        checks++;
        if (lo !== el || hi !== eh) begin
            errors++;
            $display("FAIL neg7_const: lo=%h hi=%h required lo=%h hi=%h", lo, hi, el, eh);
        end
        run_div(32'h8000_0000, 32'hFFFF_FFFF, "min_by_neg1");
`ifdef DIV_SIGNED_EN
        checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            errors++;
            $display("FAIL min_by_neg1_const: lo=%h hi=%h required lo=80000000 hi=0", lo, hi);
        end
`endif
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, "max_by_big");
        run_div(32'd0, 32'd5, "zero_dividend");
        run_div(32'd7, 32'd100, "small_by_big");
        run_div(32'hFFFF_FFFF, 32'd1, "by_one");
    endtask

    task automatic test_random;
        logic [W-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd3;
            run_div(a, b, "random");
        end
    endtask

    task automatic test_restart_ignored;
        int cyc;
        start(32'd100, 32'd7);
        repeat (4) @(negedge clk);
        divControl = 2'b01;
        dividend   = 32'd9;
        divisor    = 32'd3;
        @(negedge clk);
        divControl = 2'b00;
        cyc = 6;
        while (done !== 1'b1 && cyc < W + 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != W + 2 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL restart_ignored: done_cycle=%0d lo=%0d hi=%0d required done_cycle=%0d lo=14 hi=2", cyc, lo, hi, W + 2);
        end
    endtask

    task automatic test_reset_midrun;
        bit bad;
        start(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || lo !== '0 || hi !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: busy=%b lo=%h hi=%h done=%b required busy=0 lo=0 hi=0 done=0", busy, lo, hi, done);
        end
        bad = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_midrun_quiet: stray activity=1 required 0");
        end
    endtask

    task automatic test_abort;
        bit bad;
        run_div(32'd200, 32'd9, "pre_abort");
        start(32'd77, 32'd5);
        repeat (9) @(negedge clk);
        divControl = 2'b10;
        @(negedge clk);
        divControl = 2'b00;
        checks++;
        if (busy !== 1'b0 || lo !== 32'd22 || hi !== 32'd2) begin
            errors++;
            $display("FAIL abort: busy=%b lo=%0d hi=%0d required busy=0 lo=22 hi=2", busy, lo, hi);
        end
        bad = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad || lo !== 32'd22 || hi !== 32'd2) begin
            errors++;
            $display("FAIL abort_quiet: stray=%0d lo=%0d hi=%0d required stray=0 lo=22 hi=2", bad, lo, hi);
        end
        run_div(32'd77, 32'd5, "after_abort");
    endtask

    task automatic test_back_to_back;
        run_div(32'd123456, 32'd789, "b2b_1");
        run_div(32'd999, 32'd0, "b2b_zero");
        run_div(32'hDEAD_BEEF, 32'h1234, "b2b_2");
        run_div(32'h8000_0001, 32'h8000_0000, "b2b_3");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div0();
        test_corner();
        test_random();
        test_restart_ignored();
        test_reset_midrun();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
